seq_detector_param: RTL

Parametrised Moore serial-sequence detector, the next generation of the fixed 1001 non-overlapping detector. It compares a one-bit serial stream against a PAT_W-bit pattern that is either the power-up default or loaded at run time. Overlapping or non-overlapping detection is selectable per cycle. It emits a one-cycle registered detect pulse and keeps a saturating match count. It sits directly behind a serial input sampler and feeds event counters and interrupt logic.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/sat_counter.sv | 22 ++
 rtl/seq_detector_param.sv | 81 ++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial-sequence detector.
package seq_det_pkg;

  localparam logic [3:0] PAT_RST_DEFAULT = 4'b1001;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  // Width needed to hold a fill count in the range 0..pat_w.
  function automatic int unsigned fill_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial detector for a loadable PAT_W-bit pattern with selectable
// overlapping detection, one-cycle registered detect pulse and match count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned       PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PAT_RST = PAT_W'(PAT_RST_DEFAULT),
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal,
  input  logic             en,
  input  logic             overlap,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FW = fill_w(PAT_W);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] pat, pat_n;
  logic [PAT_W-1:0] hist, hist_n, nhist;
  logic [FW-1:0]    fill, fill_n, nfill;
  logic             det, det_n;
  logic             match;
  logic             cnt_clr, cnt_inc;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat  <= PAT_RST;
      hist <= '0;
      fill <= '0;
      det  <= 1'b0;
    end else begin
      pat  <= pat_n;
      hist <= hist_n;
      fill <= fill_n;
      det  <= det_n;
    end
  end

  // Next state: load beats sample beats idle; idle drops the pulse only
  always_comb begin
    nhist   = {hist[PAT_W-2:0], signal};
    nfill   = (fill == FILL_FULL) ? fill : fill + FW'(1);
    match   = (nfill == FILL_FULL) && (nhist == pat);
    pat_n   = pat;
    hist_n  = hist;
    fill_n  = fill;
    det_n   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (load) begin
      pat_n   = pattern_in;
      hist_n  = '0;
      fill_n  = '0;
      cnt_clr = 1'b1;
    end else if (en) begin
      hist_n  = nhist;
      det_n   = match;
      cnt_inc = match;
      // Non-overlap restarts the fill so the next hit needs PAT_W fresh bits
      fill_n  = (match && (overlap == MODE_NONOVL)) ? '0 : nfill;
    end
  end

  assign out = det;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .q   (match_cnt)
  );

endmodule
